// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Register offsets inside the 16-byte window (low two address bits ignored)
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_DIV    = 4'h8;

    // STATUS register bit positions
    localparam int unsigned STAT_FULL_BIT  = 32'd0;
    localparam int unsigned STAT_EMPTY_BIT = 32'd1;
    localparam int unsigned STAT_BUSY_BIT  = 32'd2;
    localparam int unsigned STAT_OVF_BIT   = 32'd3;
    localparam int unsigned STAT_COUNT_LSB = 32'd8;

    // A zero divisor would never finish a bit, so it is treated as one clock per bit
    function automatic logic [15:0] eff_div_f(input logic [15:0] div);
        logic [15:0] res;
        if (div == 16'd0) begin
            res = 16'd1;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_r == CW'(DEPTH));
    assign empty_o   = (count_r == {CW{1'b0}});
    assign count_o   = count_r;
    assign data_o    = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Storage array write; contents need no reset because pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: store bytes into a FIFO, shift them out 8N1.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_ena_i,
    input  logic [31:0] a_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        sel_o,
    output logic        tx_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_r;
    logic          tx_r;
    logic [7:0]    shift_r;
    logic [15:0]   baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [15:0]   eff_div_r;
    logic [15:0]   div_r;
    logic          ovf_r;

    logic [3:0]    off_s;
    logic          wr_s;
    logic          push_s;
    logic          pop_s;
    logic          baud_end_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic [7:0]    fifo_data_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign sel_o      = (a_i[31:4] == BASE_ADDR[31:4]);
    assign off_s      = {a_i[3:2], 2'b00};
    assign wr_s       = write_ena_i && sel_o;
    assign push_s     = wr_s && (off_s == OFF_TXDATA);
    assign baud_end_s = (baud_cnt_r == (eff_div_r - 16'd1));
    assign ovf_set_s  = push_s && full_s && !pop_s;
    assign ovf_clr_s  = wr_s && (off_s == OFF_STATUS) && write_data_i[STAT_OVF_BIT];
    assign tx_o       = tx_r;
    assign read_data_o = rdata_s;
    assign unused_s   = ^{a_i[1:0], write_data_i[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (write_data_i[7:0]),
        .data_o  (fifo_data_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Pop the FIFO head whenever the serialiser is ready to start a new frame
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !empty_s;
            STOP:    pop_s = baud_end_s && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Combinational register read-back from current (pre-edge) state
    always_comb begin
        rdata_s = 32'd0;
        if (sel_o) begin
            case (off_s)
                OFF_STATUS: begin
                    rdata_s[STAT_FULL_BIT]            = full_s;
                    rdata_s[STAT_EMPTY_BIT]           = empty_s;
                    rdata_s[STAT_BUSY_BIT]            = (state_r != IDLE);
                    rdata_s[STAT_OVF_BIT]             = ovf_r;
                    rdata_s[STAT_COUNT_LSB +: CW]     = count_s;
                end
                OFF_DIV:  rdata_s = {16'd0, div_r};
                default:  rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Divisor register; a change only affects frames that start afterwards
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            div_r <= DIV_RESET;
        end else if (wr_s && (off_s == OFF_DIV)) begin
            div_r <= write_data_i[15:0];
        end else begin
            div_r <= div_r;
        end
    end

    // Sticky overflow flag; a set on the same edge as a clear wins
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Frame serialiser: start bit, eight data bits LSB first, stop bit
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            tx_r       <= 1'b1;
            shift_r    <= 8'd0;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            eff_div_r  <= 16'd1;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    if (!empty_s) begin
                        shift_r   <= fifo_data_s;
                        eff_div_r <= eff_div_f(div_r);
                        state_r   <= START;
                        tx_r      <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        if (!empty_s) begin
                            shift_r   <= fifo_data_s;
                            eff_div_r <= eff_div_f(div_r);
                            tx_r      <= 1'b0;
                            state_r   <= START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_r       <= 1'b1;
                    baud_cnt_r <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, framing, FIFO limits, reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;
    localparam logic [31:0] A_OUT  = BASE + 32'h10;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;

    int errors = 0;
    int checks = 0;

    logic [31:0] d;
    logic        s;

    mmio_uart_tx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .write_ena_i  (we),
        .a_i          (addr),
        .write_data_i (wdata),
        .read_data_o  (rdata),
        .sel_o        (sel),
        .tx_o         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus store: signals set before the edge, released at the next falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic sl);
        we   = 1'b0;
        addr = a;
        #1;
        v  = rdata;
        sl = sel;
    endtask

    // Check every cycle of one frame; called at the falling edge of its first cycle
    task automatic check_frame(input logic [7:0] b, input int div);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * div; i++) begin
            we   = 1'b0;
            addr = A_STAT;
            #1;
            chk("frame_tx", {31'd0, tx}, {31'd0, fr[i / div]});
            chk("frame_busy", {31'd0, rdata[2]}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd(A_STAT, d, s);
        chk("reset_status", d, 32'h0000_0002);
        chk("reset_sel", {31'd0, s}, 32'd1);
        rd(A_DIV, d, s);
        chk("reset_div", d, 32'd434);
        chk("reset_tx", {31'd0, tx}, 32'd1);

        // Single byte, DIV=4
        wr(A_DIV, 32'd4);
        rd(A_DIV, d, s);
        chk("div_rb", d, 32'd4);
        rd(A_TX, d, s);
        chk("txdata_reads0", d, 32'd0);
        wr(A_TX, 32'h0000_00A5);
        chk("a5_before_start", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_frame(8'hA5, 4);
        rd(A_STAT, d, s);
        chk("a5_after_tx", {31'd0, tx}, 32'd1);
        chk("a5_after_status", d, 32'h0000_0002);

        // Back-to-back frames, DIV=2, no idle gap between them
        wr(A_DIV, 32'd2);
        wr(A_TX, 32'h0000_0000);
        wr(A_TX, 32'h0000_00FF);
        check_frame(8'h00, 2);
        check_frame(8'hFF, 2);
        rd(A_STAT, d, s);
        chk("b2b_after_tx", {31'd0, tx}, 32'd1);
        chk("b2b_after_status", d, 32'h0000_0002);

        // Overflow: ten consecutive pushes, one popped, eight queued, last dropped
        wr(A_DIV, 32'd100);
        for (int i = 0; i < 10; i++) begin
            wr(A_TX, 32'h10 + 32'(i));
        end
        rd(A_STAT, d, s);
        chk("ovf_status", d, 32'h0000_080D);
        wr(A_STAT, 32'h0000_0008);
        rd(A_STAT, d, s);
        chk("ovf_cleared", d, 32'h0000_0805);

        // Push while full exactly on the pop edge (stop bit of frame 1 ends)
        repeat (990) @(negedge clk);
        chk("pre_pop_tx", {31'd0, tx}, 32'd1);
        wr(A_TX, 32'h0000_0077);
        rd(A_STAT, d, s);
        chk("pop_edge_push_status", d, 32'h0000_0805);
        chk("pop_edge_tx_start", {31'd0, tx}, 32'd0);

        // Reset in the middle of a frame's data bits
        repeat (150) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(A_STAT, d, s);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_status", d, 32'h0000_0002);
        rd(A_DIV, d, s);
        chk("midrst_div", d, 32'd434);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("postrst_idle_tx", {31'd0, tx}, 32'd1);
        end
        rd(A_STAT, d, s);
        chk("postrst_status", d, 32'h0000_0002);

        // DIV=0 behaves as one clock per bit
        wr(A_DIV, 32'd0);
        rd(A_DIV, d, s);
        chk("div0_rb", d, 32'd0);
        wr(A_TX, 32'h0000_003C);
        @(negedge clk);
        check_frame(8'h3C, 1);
        rd(A_STAT, d, s);
        chk("div0_after_tx", {31'd0, tx}, 32'd1);
        chk("div0_after_status", d, 32'h0000_0002);

        // Reserved offset and out-of-window address
        rd(A_RSV, d, s);
        chk("rsv_data", d, 32'd0);
        chk("rsv_sel", {31'd0, s}, 32'd1);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_DIV, d, s);
        chk("rsv_write_div", d, 32'd0);
        rd(A_STAT, d, s);
        chk("rsv_write_status", d, 32'h0000_0002);
        rd(A_OUT, d, s);
        chk("out_data", d, 32'd0);
        chk("out_sel", {31'd0, s}, 32'd0);
        wr(A_OUT, 32'h0000_0055);
        rd(A_STAT, d, s);
        chk("out_write_status", d, 32'h0000_0002);
        repeat (2) @(negedge clk);
        chk("out_write_tx", {31'd0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
